// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The state encoding is fixed so that the unused code 2'd3 can be recovered deterministically.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter carries one spare bit so it never wraps inside an operation.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell, time-shared by the serial adder controller.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is stepped LSB first, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; operands, carry-in and counter load on the accepted start
// ADD   | one bit per edge through u_fa0; the carry flop holds the running carry
// DONE  | one-cycle done pulse; sum/cout were loaded on entry and hold until the next op
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
        $error("serial_add_ctrl: WIDTH must be within 1..32");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   s_sh_q, s_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   s_sh_shift;
    logic               last_bit;

    fa u_fa0 (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
    assign s_sh_shift = (s_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = s_sh_shift;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = s_sh_shift;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 main instance plus WIDTH=2 and WIDTH=1 instances.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    logic [8:0] q8[$];
    logic [2:0] q2[$];
    logic [1:0] q1[$];

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Called on a falling edge while the DUT is idle; returns on the falling edge after E0.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        cin8   = c;
        q8.push_back(9'(a) + 9'(b) + 9'(c));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // k counts rising edges after E0 until done is seen; nbusy counts busy samples on the way.
    task automatic wait_done8(output int k, output int nbusy, output bit ok);
        k     = 0;
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy8) nbusy++;
            if (done8) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pop8(output logic [8:0] e, output bit have);
        have = (q8.size() > 0);
        e    = have ? q8.pop_front() : 9'h1FF;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done8); end
        n_cmp++; if (sum8 !== 8'h00) begin n_bad++; $display("FAIL reset_sum: got %h want 00", sum8); end
        n_cmp++; if (cout8 !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", cout8); end
        n_cmp++; if ({busy2, busy1} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_small: got %b want 00", {busy2, busy1}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int k, nb;
        bit ok, have;
        logic [8:0] e;
        issue8(8'h0F, 8'h01, 1'b0);
        wait_done8(k, nb, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: no done within 40 cycles"); end
        n_cmp++; if (k != 8) begin n_bad++; $display("FAIL basic_latency: got %0d edges after E0 want 8", k); end
        n_cmp++; if (nb != 9) begin n_bad++; $display("FAIL basic_busy_len: got %0d cycles want 9", nb); end
        pop8(e, have);
        n_cmp++; if (!have || {cout8, sum8} !== e || e !== 9'h010) begin
            n_bad++; $display("FAIL basic_result: got %h want %h", {cout8, sum8}, 9'h010);
        end
        @(negedge clk);
        n_cmp++; if ({busy8, done8} !== 2'b00) begin n_bad++; $display("FAIL basic_release: busy/done %b want 00", {busy8, done8}); end
        n_cmp++; if ({cout8, sum8} !== 9'h010) begin n_bad++; $display("FAIL basic_hold: got %h want 010", {cout8, sum8}); end
    endtask

    task automatic test_patterns();
        logic [16:0] ops[9];
        int k, nb;
        bit ok, have;
        logic [8:0] e;
        ops[0] = {8'hFF, 8'h01, 1'b0};
        ops[1] = {8'hFF, 8'hFF, 1'b1};
        ops[2] = {8'h00, 8'h00, 1'b0};
        for (int i = 3; i < 9; i++) ops[i] = 17'($urandom);
        for (int i = 0; i < 9; i++) begin
            issue8(ops[i][16:9], ops[i][8:1], ops[i][0]);
            wait_done8(k, nb, ok);
            n_cmp++; if (!ok || k != 8) begin n_bad++; $display("FAIL pattern_latency[%0d]: got %0d edges ok=%0b want 8", i, k, ok); end
            pop8(e, have);
            n_cmp++; if (!have || {cout8, sum8} !== e) begin
                n_bad++; $display("FAIL pattern_result[%0d]: got %h want %h", i, {cout8, sum8}, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        bit have;
        logic [8:0] e;
        issue8(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (done8) ndone++;
            if (i == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
            if (i == 4) start8 = 1'b0;
            if (i == 8) begin
                n_cmp++; if (done8 !== 1'b1) begin n_bad++; $display("FAIL ignore_done_time: done %b want 1 at edge 8", done8); end
                pop8(e, have);
                n_cmp++; if (!have || {cout8, sum8} !== e || e !== 9'h046) begin
                    n_bad++; $display("FAIL ignore_result: got %h want 046", {cout8, sum8});
                end
                start8 = 1'b1;
            end
            if (i == 9) start8 = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL ignore_idle: busy %b want 0", busy8); end
    endtask

    task automatic test_reset_midop();
        int k, nb, ndone = 0;
        bit ok, have;
        logic [8:0] e;
        issue8(8'h56, 8'h78, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy8, done8} !== 2'b00) begin n_bad++; $display("FAIL midrst_ctrl: busy/done %b want 00", {busy8, done8}); end
        n_cmp++; if ({cout8, sum8} !== 9'h000) begin n_bad++; $display("FAIL midrst_result: got %h want 000", {cout8, sum8}); end
        q8.delete();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done8 || busy8) ndone++;
            @(negedge clk);
        end
        n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL midrst_quiet: %0d active cycles want 0", ndone); end
        issue8(8'h80, 8'h80, 1'b0);
        wait_done8(k, nb, ok);
        n_cmp++; if (!ok || k != 8) begin n_bad++; $display("FAIL midrst_latency: got %0d ok=%0b want 8", k, ok); end
        pop8(e, have);
        n_cmp++; if (!have || {cout8, sum8} !== e || e !== 9'h100) begin
            n_bad++; $display("FAIL midrst_fresh: got %h want 100", {cout8, sum8});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int npulse = 0, last = 0, unstable = 0, extra = 0;
        bit have;
        logic [8:0] e, held;
        held   = 9'h000;
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1;
        repeat (4) q8.push_back(9'(8'h5A) + 9'(8'hC3) + 9'd1);
        for (int i = 1; i < 80 && npulse < 4; i++) begin
            @(negedge clk);
            if (done8) begin
                npulse++;
                pop8(e, have);
                n_cmp++; if (!have || {cout8, sum8} !== e) begin
                    n_bad++; $display("FAIL b2b_result[%0d]: got %h want %h", npulse, {cout8, sum8}, e);
                end
                held = e;
                if (npulse > 1) begin
                    n_cmp++; if (i - last != 10) begin n_bad++; $display("FAIL b2b_interval: got %0d want 10", i - last); end
                end
                last = i;
                if (npulse == 4) start8 = 1'b0;
            end else if (npulse > 0 && {cout8, sum8} !== held) begin
                unstable++;
            end
        end
        n_cmp++; if (npulse != 4) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 4", npulse); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL b2b_stable: %0d changed cycles want 0", unstable); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy8 || done8) extra++;
        end
        n_cmp++; if (extra != 0 || q8.size() != 0) begin
            n_bad++; $display("FAIL b2b_stop: %0d active cycles, %0d queued want 0/0", extra, q8.size());
        end
    endtask

    task automatic test_exhaustive_small();
        int k;
        logic [2:0] e2;
        logic [1:0] e1;
        for (int a = 0; a < 4; a++) for (int b = 0; b < 4; b++) for (int c = 0; c < 2; c++) begin
            start2 = 1'b1; a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c);
            q2.push_back(3'(a + b + c));
            @(negedge clk);
            start2 = 1'b0;
            k = 0;
            while (!done2 && k < 10) begin @(negedge clk); k++; end
            e2 = (q2.size() > 0) ? q2.pop_front() : 3'bxxx;
            n_cmp++; if (k != 2) begin n_bad++; $display("FAIL w2_latency a=%0d b=%0d c=%0d: got %0d want 2", a, b, c, k); end
            n_cmp++; if ({cout2, sum2} !== e2) begin n_bad++; $display("FAIL w2_result a=%0d b=%0d c=%0d: got %h want %h", a, b, c, {cout2, sum2}, e2); end
            @(negedge clk);
        end
        for (int a = 0; a < 2; a++) for (int b = 0; b < 2; b++) for (int c = 0; c < 2; c++) begin
            start1 = 1'b1; a1 = 1'(a); b1 = 1'(b); cin1 = 1'(c);
            q1.push_back(2'(a + b + c));
            @(negedge clk);
            start1 = 1'b0;
            k = 0;
            while (!done1 && k < 10) begin @(negedge clk); k++; end
            e1 = (q1.size() > 0) ? q1.pop_front() : 2'bxx;
            n_cmp++; if (k != 1) begin n_bad++; $display("FAIL w1_latency a=%0d b=%0d c=%0d: got %0d want 1", a, b, c, k); end
            n_cmp++; if ({cout1, sum1} !== e1) begin n_bad++; $display("FAIL w1_result a=%0d b=%0d c=%0d: got %h want %h", a, b, c, {cout1, sum1}, e1); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        test_exhaustive_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
